// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller (mainfsm, aludec).
package mips_ctrl_pkg;

  // Opcodes seen in IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLE   = 6'b011111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_STOP  = 6'b111111;

  typedef enum logic [4:0] {
    S_IDLE    = 5'd0,
    S_FETCH   = 5'd1,
    S_DECODE  = 5'd2,
    S_MEMADR  = 5'd3,
    S_MEMRD   = 5'd4,
    S_MEMWB   = 5'd5,
    S_MEMWR   = 5'd6,
    S_EXECUTE = 5'd7,
    S_ALUWB   = 5'd8,
    S_BEQEX   = 5'd9,
    S_BLEEX   = 5'd10,
    S_ADDIEX  = 5'd11,
    S_ADDIWB  = 5'd12,
    S_JEX     = 5'd13,
    S_LIWB    = 5'd14,
    S_HALT    = 5'd15,
    S_FAULT   = 5'd16
  } statetype;

  // Sticky fault reason
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // ALU operation class handed to aludec
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

endpackage

// File: rtl/memwait_timer.sv
// Counts consecutive memory wait cycles; flags the cycle that hits the limit.
module memwait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  // Counter only needs to reach MEM_TIMEOUT-1: the next waiting cycle expires.
  localparam int       CW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam bit       TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] LIM = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = TO_EN && waiting && (cnt_q == LIM);

  // Next count: clear wins, otherwise advance on a wait cycle, saturating at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                       cnt_d = '0;
    else if (waiting && cnt_q != LIM) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle MIPS main controller: Moore FSM sharing one memory port.
module mainfsm
  import mips_ctrl_pkg::*;
#(
  parameter bit EXT_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_le,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       regwrite,
  output logic       byte_enable,
  output logic       res_zeroextimm,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       halted,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [4:0] state_o
);

  statetype   state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       waiting, clear, expired;

  // A wait cycle is a requested access that memory did not finish; any state
  // change (including the timeout itself) restarts the count.
  assign waiting = mem_req & ~mem_ready;
  assign clear   = mem_ready | (state_d != state_q);

  memwait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .clear   (clear),
    .expired (expired)
  );

  assign state_o     = state_q;
  assign fault_cause = cause_q;

  // State and fault-cause registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic; the fault cause is captured on the entering transition
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (expired) state_d = S_FAULT;
      S_DECODE: begin
        state_d = S_FAULT;
        if (op == OP_LW || op == OP_SW)    state_d = S_MEMADR;
        else if (EXT_EN && op == OP_SB)    state_d = S_MEMADR;
        else if (op == OP_RTYPE)           state_d = S_EXECUTE;
        else if (op == OP_BEQ)             state_d = S_BEQEX;
        else if (EXT_EN && op == OP_BLE)   state_d = S_BLEEX;
        else if (op == OP_ADDI)            state_d = S_ADDIEX;
        else if (op == OP_J)               state_d = S_JEX;
        else if (EXT_EN && op == OP_LI)    state_d = S_LIWB;
        else if (op == OP_STOP)            state_d = S_HALT;
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
                 else if (expired) state_d = S_FAULT;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
                 else if (expired) state_d = S_FAULT;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_LIWB,
      S_BEQEX, S_BLEEX, S_JEX: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_IDLE;
    endcase
    if (state_d == S_FAULT && state_q != S_FAULT)
      cause_d = expired ? FC_TIMEOUT : FC_ILLEGAL;
  end

  // Moore outputs; only FETCH looks at mem_ready to gate the IR/PC load
  always_comb begin
    mem_req        = 1'b0;
    iord           = 1'b0;
    irwrite        = 1'b0;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    branch_le      = 1'b0;
    alusrca        = 1'b0;
    regdst         = 1'b0;
    memtoreg       = 1'b0;
    memwrite       = 1'b0;
    regwrite       = 1'b0;
    byte_enable    = 1'b0;
    res_zeroextimm = 1'b0;
    pcsrc          = PCSRC_ALU;
    alusrcb        = SRCB_REG;
    aluop          = ALUOP_ADD;
    halted         = 1'b0;
    fault          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_BRIMM;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem_req     = 1'b1;
        iord        = 1'b1;
        memwrite    = 1'b1;
        byte_enable = (op == OP_SB);
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX, S_BLEEX: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc     = PCSRC_BR;
        branch    = 1'b1;
        branch_le = (state_q == S_BLEEX);
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      S_LIWB: begin
        regwrite       = 1'b1;
        res_zeroextimm = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Randomized bench: an instruction-level trace generator predicts every cycle.
module tb_mainfsm;
  import mips_ctrl_pkg::*;

  localparam bit A_EXT = 1'b1;
  localparam int A_TO  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] op = 6'b0;

  // {mem_req,iord,irwrite,pcwrite,branch,branch_le,alusrca,regdst,memtoreg,
  //  memwrite,regwrite,byte_enable,res_zeroextimm,pcsrc,alusrcb,aluop,halted,fault}
  wire [20:0] a_obs, b_obs;
  wire [1:0]  a_cause, b_cause;
  wire [4:0]  a_state, b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mainfsm #(.EXT_EN(A_EXT), .MEM_TIMEOUT(A_TO)) dut_a (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(a_obs[20]), .iord(a_obs[19]), .irwrite(a_obs[18]), .pcwrite(a_obs[17]),
    .branch(a_obs[16]), .branch_le(a_obs[15]), .alusrca(a_obs[14]), .regdst(a_obs[13]),
    .memtoreg(a_obs[12]), .memwrite(a_obs[11]), .regwrite(a_obs[10]),
    .byte_enable(a_obs[9]), .res_zeroextimm(a_obs[8]), .pcsrc(a_obs[7:6]),
    .alusrcb(a_obs[5:4]), .aluop(a_obs[3:2]), .halted(a_obs[1]), .fault(a_obs[0]),
    .fault_cause(a_cause), .state_o(a_state)
  );

  // Extensions disabled, timeout disabled
  mainfsm #(.EXT_EN(1'b0), .MEM_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(b_obs[20]), .iord(b_obs[19]), .irwrite(b_obs[18]), .pcwrite(b_obs[17]),
    .branch(b_obs[16]), .branch_le(b_obs[15]), .alusrca(b_obs[14]), .regdst(b_obs[13]),
    .memtoreg(b_obs[12]), .memwrite(b_obs[11]), .regwrite(b_obs[10]),
    .byte_enable(b_obs[9]), .res_zeroextimm(b_obs[8]), .pcsrc(b_obs[7:6]),
    .alusrcb(b_obs[5:4]), .aluop(b_obs[3:2]), .halted(b_obs[1]), .fault(b_obs[0]),
    .fault_cause(b_cause), .state_o(b_state)
  );

  typedef struct {
    statetype   st;
    logic       rdy;
    logic [1:0] cause;
  } step_t;

  step_t tr[$];

  // Strobe table straight from the per-state output list
  function automatic logic [20:0] exp_out(statetype s, logic rdy, logic [5:0] o);
    logic mr, io, ir, pw, br, bl, sa, rd, mt, mw, rw, be, rz, h, f;
    logic [1:0] pc, sb, ao;
    {mr, io, ir, pw, br, bl, sa, rd, mt, mw, rw, be, rz, h, f} = '0;
    pc = 2'b00; sb = 2'b00; ao = 2'b00;
    case (s)
      S_FETCH:  begin mr = 1; sb = 2'b01; ir = rdy; pw = rdy; end
      S_DECODE: sb = 2'b11;
      S_MEMADR, S_ADDIEX: begin sa = 1; sb = 2'b10; end
      S_MEMRD:  begin mr = 1; io = 1; end
      S_MEMWB:  begin rw = 1; mt = 1; end
      S_MEMWR:  begin mr = 1; io = 1; mw = 1; be = (o == 6'b101000); end
      S_EXECUTE: begin sa = 1; ao = 2'b10; end
      S_ALUWB:  begin rw = 1; rd = 1; end
      S_BEQEX:  begin sa = 1; ao = 2'b01; pc = 2'b01; br = 1; end
      S_BLEEX:  begin sa = 1; ao = 2'b01; pc = 2'b01; br = 1; bl = 1; end
      S_ADDIWB: rw = 1;
      S_JEX:    begin pc = 2'b10; pw = 1; end
      S_LIWB:   begin rw = 1; rz = 1; end
      S_HALT:   h = 1;
      S_FAULT:  f = 1;
      default: ;
    endcase
    return {mr, io, ir, pw, br, bl, sa, rd, mt, mw, rw, be, rz, pc, sb, ao, h, f};
  endfunction

  task automatic push(input statetype s, input logic r, input logic [1:0] c);
    step_t x;
    x.st = s; x.rdy = r; x.cause = c;
    tr.push_back(x);
  endtask

  // A memory phase of w wait cycles followed by completion, or a timeout
  task automatic mem_phase(input statetype s, input int w, output bit flt);
    int n;
    flt = (A_TO != 0) && (w >= A_TO);
    n = flt ? A_TO : w;
    for (int i = 0; i < n; i++) push(s, 1'b0, 2'b00);
    if (flt) push(S_FAULT, 1'($urandom), 2'b10);
    else     push(s, 1'b1, 2'b00);
  endtask

  // Expected state walk of one instruction starting at FETCH
  task automatic build(input logic [5:0] o, input int fw, input int mw, output bit term);
    bit f;
    term = 0;
    mem_phase(S_FETCH, fw, f);
    if (f) begin term = 1; return; end
    push(S_DECODE, 1'($urandom), 2'b00);
    if (o == 6'b100011) begin
      push(S_MEMADR, 1'($urandom), 2'b00);
      mem_phase(S_MEMRD, mw, f);
      if (f) term = 1;
      else push(S_MEMWB, 1'($urandom), 2'b00);
    end else if (o == 6'b101011 || (A_EXT && o == 6'b101000)) begin
      push(S_MEMADR, 1'($urandom), 2'b00);
      mem_phase(S_MEMWR, mw, f);
      term = f;
    end else if (o == 6'b000000) begin
      push(S_EXECUTE, 1'($urandom), 2'b00);
      push(S_ALUWB, 1'($urandom), 2'b00);
    end else if (o == 6'b000100) begin
      push(S_BEQEX, 1'($urandom), 2'b00);
    end else if (A_EXT && o == 6'b011111) begin
      push(S_BLEEX, 1'($urandom), 2'b00);
    end else if (o == 6'b001000) begin
      push(S_ADDIEX, 1'($urandom), 2'b00);
      push(S_ADDIWB, 1'($urandom), 2'b00);
    end else if (o == 6'b000010) begin
      push(S_JEX, 1'($urandom), 2'b00);
    end else if (A_EXT && o == 6'b010001) begin
      push(S_LIWB, 1'($urandom), 2'b00);
    end else if (o == 6'b111111) begin
      push(S_HALT, 1'($urandom), 2'b00);
      term = 1;
    end else begin
      push(S_FAULT, 1'($urandom), 2'b01);
      term = 1;
    end
  endtask

  // Replay the trace one cycle at a time, checking in mid-cycle
  task automatic run_trace(input logic [5:0] o, input string tag, input bit chk_b);
    step_t s;
    logic [20:0] e;
    op = o;
    while (tr.size() > 0) begin
      s = tr.pop_front();
      @(negedge clk);
      mem_ready = s.rdy;
      #1;
      e = exp_out(s.st, s.rdy, o);
      checks++;
      if (a_state !== 5'(s.st)) begin
        errors++;
        $display("FAIL %s state: got %0d want %0d", tag, a_state, s.st);
      end
      checks++;
      if (a_obs !== e) begin
        errors++;
        $display("FAIL %s strobes in state %0d: got %b want %b", tag, s.st, a_obs, e);
      end
      checks++;
      if (a_cause !== s.cause) begin
        errors++;
        $display("FAIL %s fault_cause: got %b want %b", tag, a_cause, s.cause);
      end
      if (chk_b) begin
        checks++;
        if (b_state !== 5'(s.st)) begin
          errors++;
          $display("FAIL %s noext state: got %0d want %0d", tag, b_state, s.st);
        end
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'($urandom);
    op = 6'($urandom);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (a_state !== 5'(S_IDLE) || b_state !== 5'(S_IDLE)) begin
      errors++;
      $display("FAIL %s reset state: got %0d/%0d want %0d", tag, a_state, b_state, S_IDLE);
    end
    checks++;
    if (a_obs !== 21'b0 || a_cause !== 2'b00) begin
      errors++;
      $display("FAIL %s reset outputs: got %b cause %b want all zero", tag, a_obs, a_cause);
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
    push(S_FETCH, 1'b0, 2'b00);
    run_trace(6'b000000, "reset_to_fetch", 1'b1);
  endtask

  task automatic test_lw();
    bit t;
    do_reset("lw");
    build(6'b100011, 0, 0, t);
    push(S_FETCH, 1'b0, 2'b00);
    run_trace(6'b100011, "lw", 1'b1);
  endtask

  task automatic test_sb_wait();
    bit t;
    do_reset("sb");
    build(6'b101000, 0, 3, t);
    push(S_FETCH, 1'b0, 2'b00);
    run_trace(6'b101000, "sb_wait", 1'b0);
    checks++;
    if (b_state !== 5'(S_FAULT) || b_cause !== 2'b01 || b_obs !== 21'd1) begin
      errors++;
      $display("FAIL sb_noext: got state %0d cause %b strobes %b want %0d 01 fault-only",
               b_state, b_cause, b_obs, S_FAULT);
    end
  endtask

  task automatic test_ble();
    bit t;
    do_reset("ble");
    build(6'b011111, 0, 0, t);
    push(S_FETCH, 1'b0, 2'b00);
    run_trace(6'b011111, "ble", 1'b0);
  endtask

  task automatic test_timeout();
    bit t;
    do_reset("timeout");
    build(6'b100011, 10, 0, t);
    for (int i = 0; i < 3; i++) push(S_FAULT, 1'($urandom), 2'b10);
    run_trace(6'b100011, "fetch_timeout", 1'b0);
    do_reset("timeout_recover");
    push(S_FETCH, 1'b1, 2'b00);
    run_trace(6'b000000, "timeout_recover", 1'b0);
    do_reset("memrd_timeout");
    build(6'b100011, 0, 7, t);
    push(S_FAULT, 1'($urandom), 2'b10);
    run_trace(6'b100011, "memrd_timeout", 1'b0);
  endtask

  task automatic test_halt_illegal();
    bit t;
    do_reset("halt");
    build(6'b111111, 0, 0, t);
    for (int i = 0; i < 20; i++) push(S_HALT, 1'($urandom), 2'b00);
    run_trace(6'b111111, "halt", 1'b0);
    do_reset("illegal");
    build(6'b110011, 0, 0, t);
    for (int i = 0; i < 3; i++) push(S_FAULT, 1'($urandom), 2'b01);
    run_trace(6'b110011, "illegal", 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset("reset_mid");
    push(S_FETCH, 1'b1, 2'b00);
    push(S_DECODE, 1'b0, 2'b00);
    push(S_MEMADR, 1'b0, 2'b00);
    push(S_MEMRD, 1'b0, 2'b00);
    push(S_MEMRD, 1'b0, 2'b00);
    run_trace(6'b100011, "reset_mid_pre", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (a_state !== 5'(S_IDLE) || a_obs !== 21'b0) begin
      errors++;
      $display("FAIL reset_mid: got state %0d strobes %b want %0d all zero", a_state, a_obs, S_IDLE);
    end
    for (int i = 0; i < 3; i++) push(S_FETCH, 1'b0, 2'b00);
    run_trace(6'b100011, "reset_mid_post", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] pool [13];
    logic [5:0] o;
    bit t;
    statetype last_st;
    logic [1:0] last_c;
    pool = '{6'b100011, 6'b101011, 6'b101000, 6'b000000, 6'b000100, 6'b011111,
             6'b001000, 6'b000010, 6'b010001, 6'b111111, 6'b110011, 6'b100011, 6'b000000};
    do_reset("b2b");
    for (int n = 0; n < 60; n++) begin
      o = pool[$urandom_range(0, 12)];
      build(o, $urandom_range(0, 5), $urandom_range(0, 5), t);
      if (t) begin
        last_st = tr[tr.size()-1].st;
        last_c  = tr[tr.size()-1].cause;
        for (int i = 0; i < 3; i++) push(last_st, 1'($urandom), last_c);
      end
      run_trace(o, "b2b", 1'b0);
      if (t) do_reset("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb_wait();
    test_ble();
    test_timeout();
    test_halt_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle main controller for the MIPS core: replaces the single-cycle main decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over multiple cycles, sharing one memory port through a request/ready handshake. Covers the base ISA (RTYPE, LW, SW, BEQ, ADDI, J) plus the team extensions LI, SB and BLE, which can be removed by parameter. Adds memory wait-states with a bounded timeout, a sticky fault state for illegal opcodes, and a synthesizable halt for the stop opcode. Sits beside `aludec` in the controller; the datapath consumes all strobes.

## Interface
- `EXT_EN`, 1: 1 decodes LI/SB/BLE; 0 treats them as illegal opcodes.
- `MEM_TIMEOUT`, 15: number of consecutive `mem_ready`=0 cycles in a memory state before faulting; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode from the instruction register (IR), stable after FETCH.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `iord`, `irwrite`, `pcwrite`, `branch`, `branch_le`, `alusrca`, `regdst`, `memtoreg`, `memwrite`, `regwrite`, `byte_enable`, `res_zeroextimm` out 1 each: datapath strobes.
- `pcsrc`, `alusrcb`, `aluop` out 2 each: datapath selects.
- `halted` out 1: stop opcode reached.
- `fault` out 1: sticky error.
- `fault_cause` out 2: 01 = illegal op, 10 = memory timeout.
- `state_o` out 5: current state encoding, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQEX, BLEEX, ADDIEX, ADDIWB, JEX, LIWB, HALT, FAULT.
- Outputs depend on the current state only. `irwrite`/`pcwrite` in FETCH are gated by `mem_ready`. Every strobe not listed for a state is 0.
  - IDLE: all 0.
  - FETCH: `mem_req`=1, `alusrcb`=01, `irwrite`=`pcwrite`=`mem_ready`.
  - DECODE: `alusrcb`=11.
  - MEMADR and ADDIEX: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `mem_req`=1, `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1, `byte_enable`=(op==SB).
  - EXECUTE: `alusrca`=1, `aluop`=10.
  - ALUWB: `regwrite`=1, `regdst`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - BLEEX: as BEQEX plus `branch_le`=1.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
  - LIWB: `regwrite`=1, `res_zeroextimm`=1.
  - HALT: `halted`=1.
  - FAULT: `fault`=1.
- Transitions:
  - IDLE → FETCH unconditionally.
  - FETCH → DECODE on `mem_ready`, else stay.
  - DECODE dispatch on `op`:
    - 100011 and 101011 → MEMADR.
    - 101000 → MEMADR (EXT_EN only).
    - 000000 → EXECUTE.
    - 000100 → BEQEX.
    - 011111 → BLEEX (EXT_EN only).
    - 001000 → ADDIEX.
    - 000010 → JEX.
    - 010001 → LIWB (EXT_EN only).
    - 111111 → HALT.
    - anything else → FAULT with cause 01.
  - MEMADR → MEMRD for LW; → MEMWR for SW/SB.
  - MEMRD → MEMWB on `mem_ready`. MEMWR → FETCH on `mem_ready`.
  - EXECUTE → ALUWB; ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, LIWB, BEQEX, BLEEX, JEX → FETCH.
  - HALT and FAULT are absorbing until `reset`.
- Wait counter:
  - Counts consecutive cycles with `mem_req`=1 and `mem_ready`=0; clears on `mem_ready` or on a state change.
  - When the count reaches `MEM_TIMEOUT` with `mem_ready` still 0 → FAULT with cause 10, and no strobe is issued.
- `memwrite` is held high during a wait; memory commits only on the cycle where `mem_ready`=1.

## Timing
- Reset:
  - A `reset` high at the edge loads IDLE, clears the counter and clears `fault_cause` to 00.
  - All outputs are 0 in the cycle after reset.
  - Reset mid-instruction abandons the instruction; no further strobes are issued.
- Cycles per instruction from FETCH with `mem_ready`=1:
  - LW 5.
  - SW, SB, RTYPE, ADDI 4.
  - BEQ, BLE, J, LI 3.
  - Each wait cycle adds 1.
- `fault_cause` is latched on entry to FAULT and held.
- `mem_ready` outside a memory state is ignored.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the opcode localparams (including STOP=111111);
  - the `statetype` enum (5-bit);
  - the `fault_cause` codes;
  - the aluop/pcsrc/alusrcb encodings.
  `aludec` shares the package.
- Sub-module `memwait_timer` (parametrised by `MEM_TIMEOUT`): inputs `clk`, `reset`, `waiting`, `clear`; output `expired`.
- Next-state logic and output logic live in separate `always_comb` blocks; the state register is an `always_ff`.

## Test plan
- Reset, then LW (op 100011) with `mem_ready`=1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite`=`memtoreg`=1 in cycle 5; next state FETCH.
- SB (101000) with `mem_ready` low for 3 cycles in MEMWR → `memwrite`=`byte_enable`=`mem_req`=1 for 4 cycles, then FETCH; with `EXT_EN`=0 the same opcode → FAULT, `fault_cause`=01.
- BLE (011111) → BLEEX with `branch`=`branch_le`=1, `aluop`=01, `pcsrc`=01; back to FETCH after 3 cycles total.
- `MEM_TIMEOUT`=4, `mem_ready` held 0 in FETCH → FAULT after exactly 4 wait cycles, `fault_cause`=10, `irwrite` never asserted; `reset` → IDLE, then FETCH.
- Op 111111 → HALT with `halted`=1 and `mem_req`=0 held for 20 cycles; op 110011 → FAULT with cause 01.
- `reset` asserted in MEMRD mid-LW → next cycle IDLE with all outputs 0; `regwrite` never asserted for that LW.
